// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, instruction field positions and fetch entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int WREG_HI = 12;
    localparam int WREG_LO = 10;
    localparam int REG1_HI = 9;
    localparam int REG1_LO = 7;
    localparam int REG2_HI = 6;
    localparam int REG2_LO = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] inst;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : DEPTH-entry prefetch FIFO of {inst, pc} with flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_data,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, instruction-memory issue and prefetch buffering for decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst,
    output logic [PC_W-1:0]    inst_pc,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushes,
`endif
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);
    localparam int CW = $clog2(DEPTH+1);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            push;
    logic            pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    // An outstanding request holds a slot, so a returning word always fits.
    assign occupancy  = count + CW'(inflight);
    assign imem_req   = !rst && !redirect_valid && (occupancy < CW'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign push       = inflight && !redirect_valid;
    assign wr_entry   = '{inst: imem_rdata, pc: inflight_pc};
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 1'b1;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .head    (head),
        .count   (count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pop)            perf_fetched <= perf_fetched + 1'b1;
            if (redirect_valid) perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : randomized bench for fetch_unit against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushes;
`endif

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] i;
        logic [15:0] p;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc, m_ipc, last_addr, m_fetched, m_flushes;
    bit          m_infl, e_req, e_valid;
    logic [15:0] delivered[$];
    int          vectors = 0;
    int          errors  = 0;

    function automatic logic [15:0] memword(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RESET_PC;
        m_ipc     = 16'h0000;
        m_infl    = 1'b0;
        m_fetched = 16'h0000;
        m_flushes = 16'h0000;
    endtask

    // Compare all outputs against the model in the middle of the cycle.
    task automatic sample();
        @(negedge clk);
        e_req   = !redirect_valid && (mq.size() + int'(m_infl) < DEPTH);
        e_valid = (mq.size() != 0) && !redirect_valid;
        check("imem_req",   imem_req,   e_req);
        check("imem_addr",  imem_addr,  m_pc);
        check("inst_valid", inst_valid, e_valid);
        check("inst",       inst,    (mq.size() != 0) ? mq[0].i : 16'h0000);
        check("inst_pc",    inst_pc, (mq.size() != 0) ? mq[0].p : 16'h0000);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_flushes", perf_flushes, m_flushes);
`endif
        last_addr = imem_addr;
        if (inst_valid && inst_ready) delivered.push_back(inst_pc);
    endtask

    // Apply this cycle's effects to the model, then answer the memory read.
    task automatic advance();
        if (redirect_valid) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = redirect_pc;
            m_flushes++;
        end else begin
            if (e_valid && inst_ready) begin
                void'(mq.pop_front());
                m_fetched++;
            end
            if (m_infl) mq.push_back('{memword(m_ipc), m_ipc});
            m_infl = e_req;
            if (e_req) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 16'h0001;
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = memword(last_addr);
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        model_reset();
        last_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst imem_req",   imem_req,   1'b0);
        check("rst inst_valid", inst_valid, 1'b0);
        check("rst inst",       inst,       16'h0000);
        check("rst inst_pc",    inst_pc,    16'h0000);
        rst        = 1'b0;
        inst_ready = 1'b1;

        // First fetch and two-cycle latency
        sample();
        check("C0 addr", imem_addr, 16'h0000);
        check("C0 req",  imem_req,  1'b1);
        advance();
        sample();
        check("C1 valid", inst_valid, 1'b0);
        advance();
        sample();
        check("C2 valid", inst_valid, 1'b1);
        check("C2 inst",  inst,       16'h1000);
        check("C2 pc",    inst_pc,    16'h0000);
        advance();
        repeat (3) cyc();

        // Decode stall fills the buffer, then a single pop frees a slot
        inst_ready = 1'b0;
        repeat (10) cyc();
        sample();
        check("full req",   imem_req,   1'b0);
        check("full valid", inst_valid, 1'b1);
        check("model full", mq.size(),  DEPTH);
        advance();
        inst_ready = 1'b1;
        sample();
        check("first pop req", imem_req, 1'b0);
        advance();
        inst_ready = 1'b0;
        sample();
        check("reissue req", imem_req, 1'b1);
        advance();

        // Redirect with three buffered and one in flight
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        inst_ready     = 1'b1;
        sample();
        check("pre-redirect buffered", mq.size(), 3);
        check("pre-redirect inflight", m_infl,    1'b1);
        check("R valid", inst_valid, 1'b0);
        check("R req",   imem_req,   1'b0);
        delivered.delete();
        advance();
        redirect_valid = 1'b0;
        sample();
        check("R+1 addr", imem_addr, 16'h0040);
        check("R+1 req",  imem_req,  1'b1);
        advance();
        sample();
        check("R+2 valid", inst_valid, 1'b0);
        advance();
        sample();
        check("R+3 valid", inst_valid, 1'b1);
        check("R+3 pc",    inst_pc,    16'h0040);
        check("R+3 inst",  inst,       16'h1040);
        check("flushed not delivered", delivered.size(), 1);
        advance();

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        cyc();
        redirect_pc    = 16'h0020;
        cyc();
        redirect_valid = 1'b0;
        delivered.delete();
        for (int k = 0; k < 10 && delivered.size() == 0; k++) cyc();
        check("double redirect pc", (delivered.size() != 0) ? delivered[0] : 16'hDEAD, 16'h0020);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0;
        delivered.delete();
        for (int k = 0; k < 20 && delivered.size() < 4; k++) cyc();
        check("wrap count", delivered.size() >= 4, 1'b1);
        if (delivered.size() >= 4) begin
            check("wrap pc0", delivered[0], 16'hFFFE);
            check("wrap pc1", delivered[1], 16'hFFFF);
            check("wrap pc2", delivered[2], 16'h0000);
            check("wrap pc3", delivered[3], 16'h0001);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                         : 16'($urandom);
            inst_ready     = ($urandom_range(0, 9) < 7);
            cyc();
        end

        // Asynchronous reset between edges
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (5) cyc();
        #1 rst = 1'b1;
        #1;
        check("async imem_req",   imem_req,   1'b0);
        check("async inst_valid", inst_valid, 1'b0);
        check("async inst_pc",    inst_pc,    16'h0000);
`ifdef FETCH_PERF_EN
        check("async perf_fetched", perf_fetched, 16'h0000);
        check("async perf_flushes", perf_flushes, 16'h0000);
`endif
        #1 rst = 1'b0;
        model_reset();
        sample();
        check("restart addr", imem_addr, RESET_PC);
        check("restart req",  imem_req,  1'b1);
        advance();
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

`default_nettype wire
